dcache_mem_responder: RTL and testbench
=======================================

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

Interface
REQ-001 SHALL have parameter XLEN, 32, data word width in bits.
REQ-002 SHALL have parameter LINE_WORDS, 4, words per cache line; line width LW = XLEN*LINE_WORDS = 128.
REQ-003 SHALL have parameter DEPTH, 1024, storage size in XLEN words; must be a power of 2 and a multiple of LINE_WORDS.
REQ-004 SHALL have parameter LATENCY, 2, cycles from request acceptance to the ack cycle; legal range 1..15.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port dmem_sel_i  in  1  responder selected; requests are ignored when 0.
REQ-008 SHALL have port mem_req_i  in  1  request valid from the dcache.
REQ-009 SHALL have port mem_w_en_i  in  1  1 = line write-back, 0 = line fill.
REQ-010 SHALL have port mem_addr_i  in  XLEN  byte address; bits [3:0] are ignored (line aligned).
REQ-011 SHALL have port mem_w_data_i  in  LW  write line; word k in bits [XLEN*k+XLEN-1 : XLEN*k], with word 0 at the lowest address.
REQ-012 SHALL have port mem_kill_i  in  1  abort the outstanding request.
REQ-013 SHALL have port mem_ack_o  out  1  one-cycle completion pulse.
REQ-014 SHALL have port mem_r_data_o  out  LW  fill data, same word ordering as mem_w_data_i.
REQ-015 SHALL have port busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE, when mem_req_i=1 and dmem_sel_i=1 at a rising edge, the block SHALL latch addr, w_en and w_data, load the counter with LATENCY-1 and enter WAIT; otherwise it SHALL remain in IDLE.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at counter=0 the block SHALL perform the access and enter RESP on the same edge.
REQ-019 A write SHALL store the LINE_WORDS words of the latched w_data at word indices line_idx*LINE_WORDS+k; a write SHALL leave mem_r_data_o unchanged.
REQ-020 A read SHALL register the LINE_WORDS stored words into mem_r_data_o, valid in the RESP cycle and held until the next completed read.
REQ-021 line_idx SHALL be mem_addr_i[log2(DEPTH)+1:4]; upper address bits SHALL be ignored, so addresses alias modulo DEPTH*4 bytes.
REQ-022 In RESP, mem_ack_o SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE; mem_ack_o SHALL be 0 in every other state.
REQ-023 Latency SHALL be as follows: a request accepted at edge N gives mem_ack_o=1 during the cycle after edge N+LATENCY.
REQ-024 Changes to mem_req_i or its payload after acceptance SHALL be ignored until the return to IDLE.
REQ-025 mem_kill_i=1 sampled in WAIT SHALL abort the request: no array write, no r_data update, no ack, and the next state SHALL be IDLE.
REQ-026 mem_kill_i SHALL be ignored in IDLE and RESP; an ack already in RESP completes.
REQ-027 A request in IDLE with mem_kill_i=1 on the same edge SHALL NOT be accepted.
REQ-028 mem_req_i still high in the first IDLE cycle after RESP SHALL be accepted as a new request; back-to-back throughput is one line per LATENCY+2 cycles.
REQ-029 dmem_sel_i SHALL be sampled only in IDLE; deassertion mid-transaction SHALL NOT affect completion.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, counter=0, mem_ack_o=0, mem_r_data_o=0 and busy_o=0 on the following cycle.
REQ-031 Reset during WAIT or RESP SHALL abandon the transaction: no array write and no ack.
REQ-032 Array contents SHALL NOT be reset; contents after power-up are undefined unless written.

Verification
REQ-033 Write 0x10, data {0x4,0x3,0x2,0x1} (word3..word0), LATENCY=2 -> single ack pulse 3 cycles after acceptance; busy_o high for 3 cycles.
REQ-034 Read 0x10 after REQ-033 -> mem_r_data_o=0x00000004_00000003_00000002_00000001 in the ack cycle.
REQ-035 Read 0xC0000010 -> returns the same line as 0x10 (aliasing).
REQ-036 Write 0x20 of 0xFFFF..., mem_kill_i=1 one cycle after acceptance -> no ack; busy_o drops next cycle; later read of 0x20 returns the prior contents.
REQ-037 mem_req_i held high continuously with addresses 0x0, 0x10 -> acks spaced LATENCY+2 = 4 cycles apart, with no lost or duplicated ack.
REQ-038 rst_n=0 while in WAIT of a write -> no ack; target line unchanged; outputs 0 on the cycle after reset.

Source files
------------

// File: rtl/dcache_mem_responder.sv
// Line-granular backing memory for the data cache.
// A fill or write-back completes with a one-cycle ack after a fixed latency.
module dcache_mem_responder #(
   parameter int XLEN       = 32,
   parameter int LINE_WORDS = 4,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       dmem_sel_i,
   input  logic                       mem_req_i,
   input  logic                       mem_w_en_i,
   input  logic [XLEN-1:0]            mem_addr_i,
   input  logic [XLEN*LINE_WORDS-1:0] mem_w_data_i,
   input  logic                       mem_kill_i,
   output logic                       mem_ack_o,
   output logic [XLEN*LINE_WORDS-1:0] mem_r_data_o,
   output logic                       busy_o
);

   localparam int LW     = XLEN * LINE_WORDS;
   localparam int LINES  = DEPTH / LINE_WORDS;
   localparam int LIDX_W = $clog2(LINES);
   localparam int OFF_W  = $clog2(LW / 8);
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [LIDX_W-1:0]  idx_q;
   logic               w_en_q;
   logic [LW-1:0]      w_data_q;
   logic [LW-1:0]      r_data_q;
   logic [LW-1:0]      mem_q [LINES];
   logic               accept;
   logic               access;

   // Only the line-index field selects storage; offset and upper bits alias.
   logic unused_addr;
   assign unused_addr = ^{mem_addr_i[XLEN-1:OFF_W+LIDX_W], mem_addr_i[OFF_W-1:0]};

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      access  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_req_i && dmem_sel_i && !mem_kill_i) begin
               accept  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_kill_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         r_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= CNT_W'(LATENCY - 1);
         end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (access && !w_en_q) begin
            r_data_q <= mem_q[idx_q];
         end
      end
   end

   // Request payload and array storage carry no reset.
   always_ff @(posedge clk) begin
      if (rst_n && accept) begin
         idx_q    <= mem_addr_i[OFF_W +: LIDX_W];
         w_en_q   <= mem_w_en_i;
         w_data_q <= mem_w_data_i;
      end
      if (rst_n && access && w_en_q) begin
         mem_q[idx_q] <= w_data_q;
      end
   end

   assign mem_ack_o    = (state_q == S_RESP);
   assign busy_o       = (state_q != S_IDLE);
   assign mem_r_data_o = r_data_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder with default parameters (LATENCY=2).
module tb_dcache_mem_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         dmem_sel;
   logic         mem_req;
   logic         mem_w_en;
   logic [31:0]  mem_addr;
   logic [127:0] mem_w_data;
   logic         mem_kill;
   logic         mem_ack;
   logic [127:0] mem_r_data;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] D1 = 128'h00000004_00000003_00000002_00000001;
   localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] D4 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   localparam logic [127:0] ONES = {128{1'b1}};

   dcache_mem_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dmem_sel_i   (dmem_sel),
      .mem_req_i    (mem_req),
      .mem_w_en_i   (mem_w_en),
      .mem_addr_i   (mem_addr),
      .mem_w_data_i (mem_w_data),
      .mem_kill_i   (mem_kill),
      .mem_ack_o    (mem_ack),
      .mem_r_data_o (mem_r_data),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction; payload, w_en and sel are scrambled after acceptance.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                      input logic [127:0] exp_rd, input string tag);
      mem_req    = 1'b1;
      mem_w_en   = we;
      mem_addr   = addr;
      mem_w_data = wd;
      dmem_sel   = 1'b1;
      tick();
      mem_req    = 1'b0;
      dmem_sel   = 1'b0;
      mem_w_en   = ~we;
      mem_addr   = 32'hFFFF_FFF0;
      mem_w_data = ONES;
      chk({tag, " busy_n0"}, busy, 1);
      chk({tag, " ack_n0"}, mem_ack, 0);
      tick();
      chk({tag, " busy_n1"}, busy, 1);
      chk({tag, " ack_n1"}, mem_ack, 0);
      tick();
      chk({tag, " busy_n2"}, busy, 1);
      chk({tag, " ack_n2"}, mem_ack, 1);
      chk({tag, " rdata"}, mem_r_data, exp_rd);
      tick();
      chk({tag, " busy_n3"}, busy, 0);
      chk({tag, " ack_n3"}, mem_ack, 0);
      dmem_sel = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; dmem_sel = 1'b1; mem_req = 1'b0; mem_w_en = 1'b0;
      mem_addr = '0; mem_w_data = '0; mem_kill = 1'b0;
      tick(); tick();
      chk("reset ack", mem_ack, 0);
      chk("reset busy", busy, 0);
      chk("reset rdata", mem_r_data, 0);
      rst_n = 1'b1;
      tick();

      txn(1'b1, 32'h10, D1, 128'h0, "wr10");
      txn(1'b0, 32'h10, '0, D1, "rd10");
      txn(1'b0, 32'hC000_0010, '0, D1, "rd_alias");
      txn(1'b1, 32'h20, D3, D1, "wr20");

      // Kill one cycle after acceptance.
      mem_req = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h20; mem_w_data = ONES;
      tick();
      mem_req = 1'b0;
      chk("kill busy_n0", busy, 1);
      mem_kill = 1'b1;
      tick();
      mem_kill = 1'b0;
      chk("kill busy_n1", busy, 0);
      chk("kill ack_n1", mem_ack, 0);
      tick();
      chk("kill ack_n2", mem_ack, 0);
      tick();
      chk("kill ack_n3", mem_ack, 0);
      txn(1'b0, 32'h20, '0, D3, "rd20_after_kill");

      // Kill in IDLE blocks acceptance; so does a deselected responder.
      mem_req = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h20; mem_w_data = ONES; mem_kill = 1'b1;
      tick();
      mem_kill = 1'b0; mem_req = 1'b0;
      chk("idle_kill busy", busy, 0);
      mem_req = 1'b1; dmem_sel = 1'b0;
      tick();
      mem_req = 1'b0; dmem_sel = 1'b1;
      chk("unsel busy", busy, 0);
      tick(); tick();
      chk("no_accept ack", mem_ack, 0);
      txn(1'b0, 32'h20, '0, D3, "rd20_after_blocked");

      // Back-to-back reads with mem_req held high: acks at offsets 2 and 6.
      txn(1'b1, 32'h0, D4, D3, "wr00");
      mem_req = 1'b1; mem_w_en = 1'b0; mem_addr = 32'h0;
      tick();
      mem_addr = 32'h10;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) tick();
         if (k == 4) mem_req = 1'b0;
         chk($sformatf("b2b ack k=%0d", k), mem_ack, (k == 2 || k == 6) ? 1'b1 : 1'b0);
         if (k == 2) chk("b2b rdata0", mem_r_data, D4);
         if (k == 6) chk("b2b rdata1", mem_r_data, D1);
      end

      // Reset while a write sits in WAIT.
      mem_req = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h10; mem_w_data = ONES;
      tick();
      mem_req = 1'b0;
      chk("rst_wait busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_wait ack", mem_ack, 0);
      chk("rst_wait busy0", busy, 0);
      chk("rst_wait rdata", mem_r_data, 0);
      tick();
      chk("rst_wait ack_late", mem_ack, 0);
      tick();
      chk("rst_wait ack_late2", mem_ack, 0);
      txn(1'b0, 32'h10, '0, D1, "rd10_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
